// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Snoops CPU bus writes, queues data bytes and serialises them LSB first.
module uart_tx_port #(
   parameter logic [15:0] ADDR_DATA    = 16'hFF01,
   parameter logic [15:0] ADDR_STAT    = 16'hFF02,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] stat,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          we_q;
   logic          wr_edge, data_wr, stat_wr;
   logic          full, push, pop, ovf_set, ovf_clr, baud_end;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic          unused_wdata_hi;
   assign unused_wdata_hi = ^wdata[15:8];

   // Only the rising edge of the strobe counts, so a held we writes once.
   assign wr_edge = we & ~we_q;
   assign data_wr = wr_edge & (addr == ADDR_DATA);
   assign stat_wr = wr_edge & (addr == ADDR_STAT);
   assign full    = (count_q == COUNT_FULL);

   always_comb begin
      push       = data_wr & (~full | pop);
      ovf_set    = data_wr & full & ~pop;
      ovf_clr    = stat_wr & wdata[2];
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      overflow_d = overflow_q;
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      baud_end = (baud_q == BAUD_LAST);
      case (state_q)
         S_IDLE: begin
            pop = (count_q != '0);
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
               pop     = (count_q != '0);
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
      endcase
      // A pop from IDLE or from the end of STOP both launch a new frame.
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
         bit_d   = '0;
         baud_d  = '0;
         state_d = S_START;
      end
   end

   // tx is registered from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      tx_d = 1'b1;
      if (state_q == S_START) begin
         tx_d = 1'b0;
      end else if (state_q == S_DATA) begin
         tx_d = shift_q[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         we_q       <= we;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata[7:0];
      end
   end

   assign busy = (state_q != S_IDLE) | (count_q != '0);
   assign stat = {13'b0, overflow_q, full, busy};
   assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed self-checking bench for uart_tx_port
// Runs with CLKS_PER_BIT=4 and FIFO_DEPTH=4; a line monitor decodes frames.
module tb_uart_tx_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] stat;
   logic        tx;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   int          frame_err = 0;
   logic [7:0]  rxq [$];
   logic [7:0]  m_b;
   logic        m_ok, m_ab;

   always #5 clk = ~clk;

   uart_tx_port #(
      .ADDR_DATA   (16'hFF01),
      .ADDR_STAT   (16'hFF02),
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we),
      .addr (addr),
      .wdata(wdata),
      .stat (stat),
      .tx   (tx),
      .busy (busy)
   );

   // Mid-bit sampling receiver; frames cut short by reset are discarded.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            m_ab = 1'b0;
            m_ok = 1'b1;
            repeat (2) @(negedge clk);
            if (rst_n !== 1'b1) m_ab = 1'b1;
            if (tx !== 1'b0) m_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               if (rst_n !== 1'b1) m_ab = 1'b1;
               m_b[i] = tx;
            end
            repeat (4) @(negedge clk);
            if (rst_n !== 1'b1) m_ab = 1'b1;
            if (tx !== 1'b1) m_ok = 1'b0;
            if (!m_ab) begin
               if (m_ok) rxq.push_back(m_b);
               else frame_err++;
            end
         end
      end
   end

   function automatic logic [39:0] frame_bits(input logic [7:0] b);
      logic [39:0] f;
      logic [9:0]  bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) f[i] = bits[i / 4];
      return f;
   endfunction

   function automatic logic [39:0] rx_packed();
      logic [39:0] p;
      p = '0;
      for (int i = 0; i < rxq.size() && i < 5; i++) p[8*i +: 8] = rxq[i];
      return p;
   endfunction

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic capture(input int n, output logic [79:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         v[i] = tx;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int maxc, output int n);
      n = 0;
      while ((busy !== 1'b0 || tx !== 1'b1) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL reset_stat: got %h want 0000", stat); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: tx=%b busy=%b want 1/0", tx, busy); end
   endtask

   task automatic test_single_byte();
      logic [79:0] v;
      rxq.delete();
      bus_write(16'hFF01, 16'h0055);
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_early_start: tx=%b want 1", tx); end
      @(negedge clk);
      capture(40, v);
      checks++; if (v[39:0] !== frame_bits(8'h55)) begin errors++; $display("FAIL single_frame: got %h want %h", v[39:0], frame_bits(8'h55)); end
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_after: tx=%b busy=%b want 1/0", tx, busy); end
      repeat (4) @(negedge clk);
      checks++; if (rxq.size() !== 1 || rx_packed() !== 40'h55) begin errors++; $display("FAIL single_rx: n=%0d data=%h want 1 x 55", rxq.size(), rx_packed()); end
   endtask

   task automatic test_held_strobe();
      int n;
      rxq.delete();
      we = 1'b1; addr = 16'hFF01; wdata = 16'h00A3;
      fork
         begin
            repeat (10) @(negedge clk);
            we = 1'b0;
         end
      join_none
      repeat (3) @(negedge clk);
      wait_idle(200, n);
      checks++; if (n >= 200) begin errors++; $display("FAIL held_timeout: busy=%b want 0 within 200", busy); end
      repeat (40) @(negedge clk);
      checks++; if (rxq.size() !== 1 || rx_packed() !== 40'hA3) begin errors++; $display("FAIL held_rx: n=%0d data=%h want 1 x a3", rxq.size(), rx_packed()); end
   endtask

   task automatic test_back_to_back();
      logic [79:0] v;
      logic [79:0] e;
      int n;
      rxq.delete();
      bus_write(16'hFF01, 16'h0001);
      @(negedge clk);
      bus_write(16'hFF01, 16'h0080);
      capture(80, v);
      e = {frame_bits(8'h80), frame_bits(8'h01)};
      checks++; if (v !== e) begin errors++; $display("FAIL b2b_frames: got %h want %h", v, e); end
      wait_idle(100, n);
      checks++; if (n >= 100 || rxq.size() !== 2 || rx_packed() !== 40'h8001) begin errors++; $display("FAIL b2b_rx: n=%0d data=%h want 2 x 01,80", rxq.size(), rx_packed()); end
   endtask

   task automatic test_overflow();
      int n;
      rxq.delete();
      for (int i = 0; i < 6; i++) begin
         bus_write(16'hFF01, 16'h0010 + 16'(i));
         if (i < 5) @(negedge clk);
      end
      checks++; if (stat !== 16'h0007) begin errors++; $display("FAIL ovf_stat: got %h want 0007", stat); end
      @(negedge clk);
      bus_write(16'hFF02, 16'h0004);
      checks++; if (stat !== 16'h0003) begin errors++; $display("FAIL ovf_clear: got %h want 0003", stat); end
      wait_idle(400, n);
      checks++; if (n >= 400) begin errors++; $display("FAIL ovf_timeout: busy=%b want 0 within 400", busy); end
      checks++; if (rxq.size() !== 5 || rx_packed() !== 40'h1413121110) begin errors++; $display("FAIL ovf_rx: n=%0d data=%h want 5 x 10..14", rxq.size(), rx_packed()); end
      checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL ovf_final_stat: got %h want 0000", stat); end
   endtask

   task automatic test_reset_mid_frame();
      logic bad;
      rxq.delete();
      bus_write(16'hFF01, 16'h00C3);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL midrst_stat: got %h want 0000", stat); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrst_quiet: activity=%b want 0", bad); end
      checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL midrst_rx: n=%0d want 0", rxq.size()); end
   endtask

   task automatic test_ignored_addr();
      logic bad;
      bus_write(16'h0100, 16'h00FF);
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ignored_quiet: activity=%b want 0", bad); end
      checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL ignored_stat: got %h want 0000", stat); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_held_strobe();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_ignored_addr();
      checks++; if (frame_err !== 0) begin errors++; $display("FAIL framing: got %0d bad frames want 0", frame_err); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter on the CPU data bus, in parallel with the memory block.
- Receives the same write strobe, address and write-data signals that the CPU drives into memory.
- Byte writes to its data address are queued in a small FIFO and serialised 8N1, LSB first, on a TX pin.
- A status word is presented for the top level to mux onto CPU read data or to route to the 7-segment display.

Parameters:
- ADDR_DATA, 16'hFF01, bus address of the TX data register (write-only).
- ADDR_STAT, 16'hFF02, bus address of the status register (read; write clears flags).
- CLKS_PER_BIT, 868, clock cycles per serial bit; minimum 2.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  CPU clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  bus write strobe, same signal as the memory write enable.
- addr  in  16  bus address.
- wdata  in  16  bus write data; bits [7:0] are used for data writes.
- stat  out  16  status word {13'b0, overflow, full, busy}.
- tx  out  1  serial output; idles high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, stat=0.
  - FIFO empty, overflow=0, FSM=IDLE, all counters 0.
  - Asserting reset mid-frame forces tx=1 immediately and discards queued data.
- Write detection:
  - A write is sampled on the rising edge of we: we=1 with we_q=0, where we_q is we registered.
  - Holding we for multiple cycles produces exactly one write.
  - Address is compared in the same cycle that the edge is sampled.
- Data write (addr==ADDR_DATA):
  - If the FIFO is not full, wdata[7:0] is pushed.
  - If the FIFO is full, the byte is dropped and overflow is set; overflow is sticky.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full at that edge.
- Status write (addr==ADDR_STAT):
  - wdata[2]=1 clears overflow.
  - If a clear and an overflow occur in the same cycle, overflow wins (ends at 1).
- Other addresses are ignored.
- stat is combinational from the registers: bit0=busy, bit1=full (count==FIFO_DEPTH), bit2=overflow.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; 8 bits, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a write edge sampled at clock edge N into an empty FIFO with the FSM in IDLE gives the pop at edge N+1, and tx falls at edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and resets on every bit boundary and on entry to START.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- busy = (state!=IDLE) | (count!=0), registered-state derived, no glitches.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte:
  - Stimulus: reset, then write 0x55 to 16'hFF01.
  - Response: tx falls 2 cycles later; bit pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total).
  - Then tx=1 and busy=0.
- Held strobe:
  - Stimulus: we held high for 10 cycles at 16'hFF01 with data 0xA3.
  - Response: exactly one frame, for 0xA3; FIFO count never exceeds 1.
- Back-to-back:
  - Stimulus: write 0x01 then 0x80, each a one-cycle pulse, 2 cycles apart.
  - Response: the second start bit begins on the cycle immediately after the first stop bit ends (80 contiguous frame cycles).
- Overflow:
  - Stimulus: 6 one-cycle writes 0x10..0x15 spaced 2 cycles apart.
  - Response: 0x10 transmits; 0x11..0x14 queue and stat reads 0x0007 after the 6th write; 0x15 is never transmitted.
  - Then write 16'h0004 to 16'hFF02; stat bit2 returns to 0.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during DATA bit 3 of a frame.
  - Response: tx=1 immediately, busy=0, stat=0; no further frames after release.
- Ignored address:
  - Stimulus: write 0xFF to 16'h0100.
  - Response: tx stays 1 and busy stays 0.
